// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalize/round datapath.
// Rounding-mode encodings, GRS bit positions and default field widths.
package fp_pkg;

    localparam int DEF_EXPONENT_SIZE = 8;
    localparam int DEF_FRACTION_SIZE = 23;

    localparam int LSB_IDX    = 3;
    localparam int GUARD_IDX  = 2;
    localparam int ROUND_IDX  = 1;
    localparam int STICKY_IDX = 0;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } round_mode_e;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter.
// Count equals Width when Data is all zero; AllZero flags that case.
module fp_lzc #(
    parameter int Width      = 27,
    parameter int CountWidth = $clog2(Width) + 1
) (
    input  logic [Width-1:0]      Data,
    output logic [CountWidth-1:0] Count,
    output logic                  AllZero
);

    // Highest set bit wins: later loop iterations override earlier ones.
    always_comb begin
        Count = CountWidth'(Width);
        for (int i = 0; i < Width; i++) begin
            if (Data[i]) begin
                Count = CountWidth'(Width - 1 - i);
            end
        end
    end

    assign AllZero = ~|Data;

endmodule

// File: rtl/fp_norm_round_pipe.sv
// Two-stage normalize-and-round unit with valid/ready on both sides.
// Define FPU_ROUND_MODES_EN to honour RoundMode; otherwise always RNE.
module fp_norm_round_pipe
    import fp_pkg::*;
#(
    parameter int ExponentSize = DEF_EXPONENT_SIZE,
    parameter int FractionSize = DEF_FRACTION_SIZE
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic                    InSign,
    input  logic [ExponentSize-1:0] InExponent,
    input  logic                    InCarry,
    input  logic [FractionSize+3:0] InMantissa,
    input  logic [1:0]              RoundMode,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    OutSign,
    output logic [ExponentSize-1:0] OutExponent,
    output logic [FractionSize-1:0] OutFraction,
    output logic                    Overflow,
    output logic                    Underflow,
    output logic                    Inexact,
    output logic                    Zero
);

    localparam int MantissaSize = FractionSize + 1;
    localparam int RoundingSize = MantissaSize + 3;
    localparam int ExpWidth     = ExponentSize + 2;
    localparam int LzWidth      = $clog2(RoundingSize) + 1;
    localparam logic signed [ExpWidth-1:0] ExpMax =
        ExpWidth'((2 ** ExponentSize) - 1);

    logic        adv1, adv2;
    round_mode_e eff_mode;

    logic [LzWidth-1:0]         lz_cnt;
    logic                       lz_zero;
    logic signed [ExpWidth-1:0] exp_in, lz_ext;

    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_sign_q, s1_sign_d;
    logic                       s1_zero_q, s1_zero_d;
    logic                       s1_unf_q, s1_unf_d;
    round_mode_e                s1_mode_q, s1_mode_d;
    logic signed [ExpWidth-1:0] s1_exp_q, s1_exp_d;
    logic [RoundingSize-1:0]    s1_mant_q, s1_mant_d;

    logic                       rnd_inc, rnd_grs, rnd_ovf, rnd_to_inf;
    logic [MantissaSize:0]      rnd_sum;
    logic signed [ExpWidth-1:0] rnd_exp;
    logic                       unused_hidden;

    logic                    out_valid_q, out_valid_d;
    logic                    out_sign_q, out_sign_d;
    logic [ExponentSize-1:0] out_exp_q, out_exp_d;
    logic [FractionSize-1:0] out_frac_q, out_frac_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    inx_q, inx_d;
    logic                    zero_q, zero_d;

`ifdef FPU_ROUND_MODES_EN
    assign eff_mode = round_mode_e'(RoundMode);
`else
    logic unused_round_mode;
    assign unused_round_mode = ^RoundMode;
    assign eff_mode = RM_RNE;
`endif

    assign adv2    = !out_valid_q || OutReady;
    assign adv1    = !s1_valid_q || adv2;
    assign InReady = adv1;

    fp_lzc #(
        .Width      (RoundingSize),
        .CountWidth (LzWidth)
    ) u_lzc (
        .Data    (InMantissa),
        .Count   (lz_cnt),
        .AllZero (lz_zero)
    );

    assign exp_in = $signed({2'b00, InExponent});
    assign lz_ext = ExpWidth'(lz_cnt);

    // Stage 1: normalize the adder result and capture it on accept.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_zero_d  = s1_zero_q;
        s1_unf_d   = s1_unf_q;
        s1_mode_d  = s1_mode_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        if (adv1) begin
            s1_valid_d = InValid;
        end
        if (adv1 && InValid) begin
            s1_sign_d = InSign;
            s1_mode_d = eff_mode;
            s1_zero_d = 1'b0;
            s1_unf_d  = 1'b0;
            if (InCarry) begin
                s1_mant_d = {1'b1, InMantissa[RoundingSize-1:2],
                             |InMantissa[1:0]};
                s1_exp_d  = exp_in + ExpWidth'(1);
            end else if (lz_zero) begin
                s1_mant_d = '0;
                s1_exp_d  = '0;
                s1_zero_d = 1'b1;
                s1_sign_d = (eff_mode == RM_RDN);
            end else if (lz_ext >= exp_in) begin
                s1_mant_d = '0;
                s1_exp_d  = '0;
                s1_zero_d = 1'b1;
                s1_unf_d  = 1'b1;
            end else begin
                s1_mant_d = InMantissa << lz_cnt;
                s1_exp_d  = exp_in - lz_ext;
            end
        end
    end

    // Stage 2 datapath: rounding increment, renormalize, overflow select.
    always_comb begin
        rnd_grs = s1_mant_q[GUARD_IDX] | s1_mant_q[ROUND_IDX]
                | s1_mant_q[STICKY_IDX];
        unique case (s1_mode_q)
            RM_RNE: rnd_inc = s1_mant_q[GUARD_IDX]
                            & (s1_mant_q[ROUND_IDX] | s1_mant_q[STICKY_IDX]
                               | s1_mant_q[LSB_IDX]);
            RM_RTZ: rnd_inc = 1'b0;
            RM_RUP: rnd_inc = !s1_sign_q && rnd_grs;
            RM_RDN: rnd_inc = s1_sign_q && rnd_grs;
            default: rnd_inc = 1'b0;
        endcase
        rnd_sum = {1'b0, s1_mant_q[RoundingSize-1:LSB_IDX]}
                + (MantissaSize + 1)'(rnd_inc);
        rnd_exp = s1_exp_q + ExpWidth'(rnd_sum[MantissaSize]);
        rnd_ovf = !s1_zero_q && (rnd_exp >= ExpMax);
        rnd_to_inf = (s1_mode_q == RM_RNE)
                  || (s1_mode_q == RM_RUP && !s1_sign_q)
                  || (s1_mode_q == RM_RDN && s1_sign_q);
    end

    assign unused_hidden = rnd_sum[FractionSize];

    // Stage 2 output register: loads when the output slot is free or drains.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_exp_d   = out_exp_q;
        out_frac_d  = out_frac_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;
        zero_d      = zero_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
        end
        if (adv2 && s1_valid_q) begin
            out_sign_d = s1_sign_q;
            unf_d      = s1_unf_q;
            zero_d     = s1_zero_q;
            ovf_d      = rnd_ovf;
            inx_d      = rnd_grs || rnd_ovf;
            if (rnd_ovf) begin
                out_exp_d  = rnd_to_inf ? {ExponentSize{1'b1}}
                                        : {{(ExponentSize-1){1'b1}}, 1'b0};
                out_frac_d = rnd_to_inf ? '0 : '1;
            end else begin
                out_exp_d  = rnd_exp[ExponentSize-1:0];
                out_frac_d = rnd_sum[MantissaSize] ? '0
                           : rnd_sum[FractionSize-1:0];
            end
        end
    end

    // Pipeline state with synchronous reset discarding in-flight data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_unf_q    <= 1'b0;
            s1_mode_q   <= RM_RNE;
            s1_exp_q    <= '0;
            s1_mant_q   <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_frac_q  <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_unf_q    <= s1_unf_d;
            s1_mode_q   <= s1_mode_d;
            s1_exp_q    <= s1_exp_d;
            s1_mant_q   <= s1_mant_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_exp_q   <= out_exp_d;
            out_frac_q  <= out_frac_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
            zero_q      <= zero_d;
        end
    end

    assign OutValid    = out_valid_q;
    assign OutSign     = out_sign_q;
    assign OutExponent = out_exp_q;
    assign OutFraction = out_frac_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;
    assign Inexact     = inx_q;
    assign Zero        = zero_q;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Scoreboard bench for fp_norm_round_pipe (default 8/23 format).
// Expected results follow FPU_ROUND_MODES_EN when it is defined.
module tb_fp_norm_round_pipe;

`ifdef FPU_ROUND_MODES_EN
    localparam bit MODES_EN = 1'b1;
`else
    localparam bit MODES_EN = 1'b0;
`endif

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    logic        Clk, Reset;
    logic        InValid, InReady, InSign, InCarry;
    logic [7:0]  InExponent;
    logic [26:0] InMantissa;
    logic [1:0]  RoundMode;
    logic        OutValid, OutReady, OutSign;
    logic [7:0]  OutExponent;
    logic [22:0] OutFraction;
    logic        Overflow, Underflow, Inexact, Zero;

    logic [35:0] sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_out = 0;

    fp_norm_round_pipe dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .InValid     (InValid),
        .InReady     (InReady),
        .InSign      (InSign),
        .InExponent  (InExponent),
        .InCarry     (InCarry),
        .InMantissa  (InMantissa),
        .RoundMode   (RoundMode),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutSign     (OutSign),
        .OutExponent (OutExponent),
        .OutFraction (OutFraction),
        .Overflow    (Overflow),
        .Underflow   (Underflow),
        .Inexact     (Inexact),
        .Zero        (Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [35:0] ex(input logic s, input logic [7:0] e,
                                       input logic [22:0] f, input logic o,
                                       input logic u, input logic i,
                                       input logic z);
        return {s, e, f, o, u, i, z};
    endfunction

    function automatic logic [35:0] act_vec();
        return {OutSign, OutExponent, OutFraction,
                Overflow, Underflow, Inexact, Zero};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Issue one item; the expectation is queued once it is accepted.
    task automatic send(input logic s, input logic [7:0] e, input logic c,
                        input logic [26:0] m, input logic [1:0] rm,
                        input logic [35:0] x);
        int t = 0;
        @(negedge Clk);
        InValid = 1'b1;
        InSign = s;
        InExponent = e;
        InCarry = c;
        InMantissa = m;
        RoundMode = rm;
        #1;
        while (!InReady && t < 20) begin
            @(negedge Clk);
            #1;
            t++;
        end
        if (!InReady) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=InReady 0 expected=1");
            InValid = 1'b0;
        end else begin
            sb_q.push_back(x);
            @(posedge Clk);
            #1;
            InValid = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (sb_q.size() != 0 && t < 30) begin
            @(negedge Clk);
            t++;
        end
        repeat (3) @(negedge Clk);
        chk(nm, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: compare each transferred result against the queue head.
    initial begin
        forever begin
            @(negedge Clk);
            #2;
            if (!Reset && OutValid && OutReady) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h expected=none",
                             act_vec());
                end else begin
                    chk($sformatf("item%0d", n_out), 64'(act_vec()),
                        64'(sb_q.pop_front()));
                end
                n_out++;
            end
        end
    end

    initial begin
        Reset = 1'b1;
        InValid = 1'b0;
        InSign = 1'b0;
        InExponent = '0;
        InCarry = 1'b0;
        InMantissa = '0;
        RoundMode = RNE;
        OutReady = 1'b1;
        repeat (2) @(negedge Clk);
        chk("reset_outvalid", 64'(OutValid), 64'd0);
        chk("reset_outputs", 64'(act_vec()), 64'd0);
        Reset = 1'b0;
        #1;
        chk("reset_inready", 64'(InReady), 64'd1);

        send(0, 8'd127, 0, {24'h800000, 3'b000}, RNE,
             ex(0, 8'd127, 23'h0, 0, 0, 0, 0));
        send(0, 8'd127, 0, {24'h800000, 3'b100}, RNE,
             ex(0, 8'd127, 23'h0, 0, 0, 1, 0));
        send(0, 8'd127, 0, {24'h800001, 3'b100}, RNE,
             ex(0, 8'd127, 23'h2, 0, 0, 1, 0));
        send(0, 8'd254, 1, {24'hFFFFFF, 3'b000}, RNE,
             ex(0, 8'd255, 23'h0, 1, 0, 1, 0));
        send(0, 8'd254, 1, {24'hFFFFFF, 3'b000}, RTZ,
             MODES_EN ? ex(0, 8'd254, 23'h7FFFFF, 1, 0, 1, 0)
                      : ex(0, 8'd255, 23'h0, 1, 0, 1, 0));
        send(0, 8'd10, 0, {24'h000100, 3'b000}, RNE,
             ex(0, 8'd0, 23'h0, 0, 1, 0, 1));
        // 24'h000100 has 15 leading zeros in the 27-bit field: 20-15=5.
        send(0, 8'd20, 0, {24'h000100, 3'b000}, RNE,
             ex(0, 8'd5, 23'h0, 0, 0, 0, 0));
        send(0, 8'd90, 0, 27'd0, RDN,
             ex(MODES_EN, 8'd0, 23'h0, 0, 0, 0, 1));
        send(0, 8'd127, 0, {24'h800000, 3'b001}, RUP,
             ex(0, 8'd127, MODES_EN ? 23'h1 : 23'h0, 0, 0, 1, 0));
        send(1, 8'd127, 0, {24'h800000, 3'b010}, RDN,
             ex(1, 8'd127, MODES_EN ? 23'h1 : 23'h0, 0, 0, 1, 0));
        send(0, 8'd100, 0, {24'hFFFFFF, 3'b100}, RNE,
             ex(0, 8'd101, 23'h0, 0, 0, 1, 0));
        send(1, 8'd20, 1, {24'h800000, 3'b011}, RNE,
             ex(1, 8'd21, 23'h400000, 0, 0, 1, 0));
        drain("directed_drain");

        // Back-pressure: two items fill the pipe, the third must wait.
        @(negedge Clk);
        OutReady = 1'b0;
        send(0, 8'd50, 0, {24'h800000, 3'b000}, RNE,
             ex(0, 8'd50, 23'h0, 0, 0, 0, 0));
        send(0, 8'd51, 0, {24'h800000, 3'b000}, RNE,
             ex(0, 8'd51, 23'h0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            InValid = 1'b1;
            InExponent = 8'd52;
            InMantissa = {24'h800000, 3'b000};
            #1;
            chk($sformatf("stall_inready%0d", i), 64'(InReady), 64'd0);
            chk($sformatf("stall_hold%0d", i),
                64'({OutValid, OutExponent}), 64'({1'b1, 8'd50}));
        end
        @(negedge Clk);
        OutReady = 1'b1;
        #1;
        chk("release_inready", 64'(InReady), 64'd1);
        sb_q.push_back(ex(0, 8'd52, 23'h0, 0, 0, 0, 0));
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        send(0, 8'd53, 0, {24'h800000, 3'b000}, RNE,
             ex(0, 8'd53, 23'h0, 0, 0, 0, 0));
        drain("bp_drain");
        chk("bp_outputs_seen", 64'(n_out), 64'd16);

        // Reset with two items in flight: nothing stale may emerge.
        @(negedge Clk);
        OutReady = 1'b0;
        send(0, 8'd60, 0, {24'h800000, 3'b000}, RNE,
             ex(0, 8'd60, 23'h0, 0, 0, 0, 0));
        send(0, 8'd61, 0, {24'h800000, 3'b000}, RNE,
             ex(0, 8'd61, 23'h0, 0, 0, 0, 0));
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        sb_q.delete();
        #2;
        chk("midreset_outvalid", 64'(OutValid), 64'd0);
        chk("midreset_outputs", 64'(act_vec()), 64'd0);
        chk("midreset_inready", 64'(InReady), 64'd1);
        OutReady = 1'b1;
        repeat (5) @(negedge Clk);
        send(1, 8'd70, 0, {24'h400000, 3'b000}, RNE,
             ex(1, 8'd69, 23'h0, 0, 0, 0, 0));
        drain("post_reset_drain");
        chk("total_outputs", 64'(n_out), 64'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
